// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_pkg
//  Description : Shared constants and helpers for the pipelined arithmetic
//                blocks: add/sub mode encoding, chunk-width derivation and
//                configuration legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

    // Mode encoding on the 'sub' input
    localparam logic c_MODE_ADD = 1'b0;
    localparam logic c_MODE_SUB = 1'b1;

    // Width of the slice each pipeline stage processes
    function automatic int calc_cw(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // Legal configuration: 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage : pipelined_adder_pkg
`default_nettype wire

// File: rtl/pipe_add_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_add_stage
//  Description : Combinational CW-bit chunk adder. Produces the chunk sum,
//                the carry out of the chunk MSB and the carry into the chunk
//                MSB (needed for signed-overflow detection in the top chunk).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_add_stage
    import pipelined_adder_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_c,
    output logic [CW-1:0] o_s,
    output logic          o_c,
    output logic          o_msb_c
);

    logic [CW:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_c};
    assign o_s     = w_full[CW-1:0];
    assign o_c     = w_full[CW];
    // Carry into the MSB recovered from the MSB sum bit and its two operands
    assign o_msb_c = w_full[CW-1] ^ i_a[CW-1] ^ i_b[CW-1];

endmodule : pipe_add_stage
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : WIDTH-bit adder/subtractor split into STAGES chunks. The
//                carry ripples one chunk per clock through registered stages.
//                Valid/ready on both sides; the whole pipeline stalls when the
//                output is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int c_CW = calc_cw(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // Stage inputs: what stage k sees this cycle (ports for k=0, stage k-1 regs otherwise)
    logic             w_v_in [STAGES];
    logic [WIDTH-1:0] w_a_in [STAGES];
    logic [WIDTH-1:0] w_b_in [STAGES];
    logic [WIDTH-1:0] w_r_in [STAGES];
    logic             w_c_in [STAGES];

    // Chunk adder results and next-state result words
    logic [c_CW-1:0]  w_s    [STAGES];
    logic             w_co   [STAGES];
    logic             w_mc   [STAGES];
    logic [WIDTH-1:0] w_r_nx [STAGES];

    // Stage registers; the last stage doubles as the output register
    logic             r_v    [STAGES];
    logic [WIDTH-1:0] r_a    [STAGES];
    logic [WIDTH-1:0] r_b    [STAGES];
    logic [WIDTH-1:0] r_r    [STAGES];
    logic             r_c    [STAGES];
    logic             r_ovf;

    logic             w_adv;

    // Whole pipeline moves whenever the tail slot is empty or being drained
    assign w_adv     = !r_v[STAGES-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_r[STAGES-1];
    assign c_out     = r_c[STAGES-1];
    assign ovf       = r_ovf;

    // Route ports into stage 0 and each stage register into the following stage
    always_comb begin
        w_v_in[0] = in_valid;
        w_a_in[0] = a;
        w_b_in[0] = (sub == c_MODE_SUB) ? ~b : b;
        w_c_in[0] = (sub == c_MODE_SUB) ? 1'b1 : c_in;
        w_r_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k] = r_v[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_c_in[k] = r_c[k-1];
            w_r_in[k] = r_r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_add_stage #(
            .CW      (c_CW)
        ) u_add (
            .i_a     (w_a_in[k][k*c_CW +: c_CW]),
            .i_b     (w_b_in[k][k*c_CW +: c_CW]),
            .i_c     (w_c_in[k]),
            .o_s     (w_s[k]),
            .o_c     (w_co[k]),
            .o_msb_c (w_mc[k])
        );
    end

    // Merge each stage's freshly computed chunk into its skewed result word
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_r_nx[k]                     = w_r_in[k];
            w_r_nx[k][k*c_CW +: c_CW]     = w_s[k];
        end
    end

    // Stage registers: cleared on reset, shift together on advance, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_r[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_in[k];
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_r[k] <= w_r_nx[k];
                r_c[k] <= w_co[k];
            end
            r_ovf <= w_co[STAGES-1] ^ w_mc[STAGES-1];
        end
    end

endmodule : pipelined_adder
`default_nettype wire
